cc_branch_unit: RTL and testbench
=================================

Name: cc_branch_unit

Overview:
Parametrised condition-code and branch-enable unit for the LC-3 datapath; the next generation of the single NZP/BEN block. Captures N/Z/P plus V/C status from the bus and ALU, evaluates branch conditions in several modes, and holds a small LIFO of saved condition codes for interrupt entry and RTI. Sits beside the IR and bus mux; BEN_Out feeds the control FSM.

Parameters:
DATA_W, 16, width of Bus_In and of the zero/sign test
STACK_DEPTH, 4, number of saved CC entries (>=1)
COND_LSB, 9, IR bit index of the P test bit; Z is COND_LSB+1, N is COND_LSB+2

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  asynchronous, active-low reset
Bus_In  in  DATA_W  value being written to the register file
IR  in  16  current instruction register
LD_CC  in  1  load condition codes from Bus_In/Ovf_In/Carry_In
LD_BEN  in  1  load branch-enable flop
Cmp_Unsigned  in  1  1: N forced 0, sign bit treated as magnitude
Ovf_In  in  1  ALU overflow for V
Carry_In  in  1  ALU carry for C
Cond_Mode  in  2  branch evaluation mode
Save_CC  in  1  push current CC onto stack
Restore_CC  in  1  pop stack into CC
BEN_Out  out  1  registered branch enable
NZP_Out  out  3  registered {N,Z,P}
VC_Out  out  2  registered {V,C}
Stack_Full  out  1  STACK_DEPTH entries held
Stack_Empty  out  1  no entries held
Stack_Err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (Reset=0, asynchronous): NZP=010, VC=00, BEN_Out=0, stack pointer=0, Stack_Empty=1, Stack_Full=0, Stack_Err=0. Stack entry contents don't-care.
- CC register 5 bits {N,Z,P,V,C}. Outputs are direct flop values; no combinational path from inputs to outputs.
- LD_CC next value: Z = (Bus_In == 0); N = Bus_In[DATA_W-1] & ~Cmp_Unsigned & ~Z; P = ~N & ~Z; V = Ovf_In; C = Carry_In. Exactly one of N/Z/P is set after every load.
- Branch term b computed from the current registered CC (pre-edge value) and IR:
  Cond_Mode 00: (N&IR[COND_LSB+2])|(Z&IR[COND_LSB+1])|(P&IR[COND_LSB])
  01: C&IR[COND_LSB]; 10: V&IR[COND_LSB]; 11: 1.
- LD_BEN: BEN_Out <= b one edge later. If LD_CC and LD_BEN are asserted together, BEN uses the old CC.
- Stack: pointer counts 0..STACK_DEPTH. Save_CC pushes pre-edge CC into entry[ptr] and increments ptr. Restore_CC loads CC from entry[ptr-1] and decrements ptr.
- Priority on the CC register: Restore_CC > LD_CC > hold.
- Save_CC with LD_CC: the old CC is pushed and the new value is loaded, in the same edge.
- Save_CC with Restore_CC in the same cycle: no-op. Pointer, CC and stack are unchanged, Stack_Err is not set, and LD_CC still applies.
- Save when Stack_Full: push is dropped, ptr holds, and Stack_Err is set.
- Restore when Stack_Empty: CC is unchanged (LD_CC still applies if asserted), ptr holds, and Stack_Err is set.
- Stack_Err is sticky; it clears only on reset.
- Stack_Full = (ptr == STACK_DEPTH). Stack_Empty = (ptr == 0). Both are derived from the registered ptr.
- Reset asserted mid-operation: all state returns to reset values immediately. The first edge after deassertion behaves as an ordinary cycle.

Test Plan:
- Reset then LD_CC with Bus_In=16'h8000, Cmp_Unsigned=0 -> NZP_Out=100. Repeat with Cmp_Unsigned=1 -> NZP_Out=001. Bus_In=0 -> NZP_Out=010.
- CC=001, IR[11:9]=001, Cond_Mode=00, LD_BEN and LD_CC (Bus_In=0) in the same cycle -> BEN_Out=1 (old CC) and NZP_Out=010. Next LD_BEN -> BEN_Out=0.
- Cond_Mode=01: LD_CC with Carry_In=1, IR[9]=1, then LD_BEN -> BEN_Out=1. Cond_Mode=10 with V=0 -> BEN_Out=0. Cond_Mode=11 -> BEN_Out=1.
- Push CC values 100, 010, 001, 100 (STACK_DEPTH=4) -> Stack_Full=1. A fifth Save -> Stack_Err=1, no change. Four Restores return 100, 001, 010, 100 in that order, then Stack_Empty=1.
- Restore when empty, with LD_CC Bus_In=5 -> NZP_Out=001, Stack_Err=1. Save+Restore together with ptr=2 -> ptr stays 2, CC unchanged.
- Drive Reset low asynchronously between edges during a push sequence -> all outputs go to reset values before the next edge, and Stack_Err clears.

Source files
------------

// File: rtl/cc_branch_unit_if.sv
// Signal bundle between the LC-3 datapath/control and the condition-code and branch unit.
// The master side drives the load strobes and operands; the slave side returns flags.
interface cc_branch_unit_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] Bus_In;
  logic [15:0]       IR;
  logic              LD_CC;
  logic              LD_BEN;
  logic              Cmp_Unsigned;
  logic              Ovf_In;
  logic              Carry_In;
  logic [1:0]        Cond_Mode;
  logic              Save_CC;
  logic              Restore_CC;
  logic              BEN_Out;
  logic [2:0]        NZP_Out;
  logic [1:0]        VC_Out;
  logic              Stack_Full;
  logic              Stack_Empty;
  logic              Stack_Err;

  modport master (
    output Bus_In, IR, LD_CC, LD_BEN, Cmp_Unsigned, Ovf_In, Carry_In, Cond_Mode,
           Save_CC, Restore_CC,
    input  BEN_Out, NZP_Out, VC_Out, Stack_Full, Stack_Empty, Stack_Err
  );

  modport slave (
    input  Bus_In, IR, LD_CC, LD_BEN, Cmp_Unsigned, Ovf_In, Carry_In, Cond_Mode,
           Save_CC, Restore_CC,
    output BEN_Out, NZP_Out, VC_Out, Stack_Full, Stack_Empty, Stack_Err
  );
endinterface

// File: rtl/cc_branch_unit.sv
// Condition-code register {N,Z,P,V,C}, branch-enable flop and a small LIFO of saved
// condition codes used across interrupt entry / RTI.
module cc_branch_unit #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned COND_LSB    = 9
) (
  input logic             Clk,
  input logic             Reset,
  cc_branch_unit_if.slave bus
);

  localparam int unsigned PtrW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef logic [4:0] cc_t;  // {N, Z, P, V, C}

  cc_t             cc_q, cc_d, cc_load;
  logic            ben_q, ben_d;
  logic            err_q, err_d;
  logic [PtrW-1:0] ptr_q, ptr_d, ptr_dec;
  cc_t             stack_q [STACK_DEPTH];
  cc_t             stack_d [STACK_DEPTH];

  logic            full, empty;
  logic            push_req, pop_req, do_push, do_pop;
  logic            zero, neg, branch;
  logic [IdxW-1:0] wr_idx, rd_idx;

  assign full    = (ptr_q == PtrW'(STACK_DEPTH));
  assign empty   = (ptr_q == '0);
  assign ptr_dec = ptr_q - PtrW'(1);
  assign wr_idx  = ptr_q[IdxW-1:0];
  assign rd_idx  = ptr_dec[IdxW-1:0];

  // Simultaneous save and restore cancel each other out entirely.
  assign push_req = bus.Save_CC & ~bus.Restore_CC;
  assign pop_req  = bus.Restore_CC & ~bus.Save_CC;
  assign do_push  = push_req & ~full;
  assign do_pop   = pop_req & ~empty;

  assign zero    = (bus.Bus_In == '0);
  assign neg     = bus.Bus_In[DATA_W-1] & ~bus.Cmp_Unsigned & ~zero;
  assign cc_load = {neg, zero, ~neg & ~zero, bus.Ovf_In, bus.Carry_In};

  // Branch term always looks at the registered CC, so a same-cycle LD_CC is not seen.
  always_comb begin
    branch = 1'b0;
    case (bus.Cond_Mode)
      2'b00: branch = (cc_q[4] & bus.IR[COND_LSB+2]) |
                      (cc_q[3] & bus.IR[COND_LSB+1]) |
                      (cc_q[2] & bus.IR[COND_LSB]);
      2'b01: branch = cc_q[0] & bus.IR[COND_LSB];
      2'b10: branch = cc_q[1] & bus.IR[COND_LSB];
      2'b11: branch = 1'b1;
      default: branch = 1'b0;
    endcase
  end

  always_comb begin
    cc_d  = cc_q;
    ben_d = ben_q;
    ptr_d = ptr_q;
    err_d = err_q | (push_req & full) | (pop_req & empty);

    if (do_pop) begin
      cc_d = stack_q[rd_idx];
    end else if (bus.LD_CC) begin
      cc_d = cc_load;
    end

    if (bus.LD_BEN) begin
      ben_d = branch;
    end

    if (do_push) begin
      ptr_d = ptr_q + PtrW'(1);
    end else if (do_pop) begin
      ptr_d = ptr_dec;
    end
  end

  always_comb begin
    stack_d = stack_q;
    if (do_push) begin
      stack_d[wr_idx] = cc_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cc_q  <= 5'b01000;
      ben_q <= 1'b0;
      err_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      cc_q  <= cc_d;
      ben_q <= ben_d;
      err_q <= err_d;
      ptr_q <= ptr_d;
    end
  end

  // Stack contents are don't-care after reset; the pointer alone defines validity.
  always_ff @(posedge Clk) begin
    stack_q <= stack_d;
  end

  assign bus.BEN_Out     = ben_q;
  assign bus.NZP_Out     = cc_q[4:2];
  assign bus.VC_Out      = cc_q[1:0];
  assign bus.Stack_Full  = full;
  assign bus.Stack_Empty = empty;
  assign bus.Stack_Err   = err_q;

  logic unused_ir;
  assign unused_ir = ^bus.IR;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed bench for cc_branch_unit: CC loads, branch modes, CC stack and async reset.
module tb_cc_branch_unit;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  cc_branch_unit_if #(.DATA_W(16)) bus ();

  cc_branch_unit #(
    .DATA_W     (16),
    .STACK_DEPTH(4),
    .COND_LSB   (9)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cc(input string tag, input logic [2:0] nzp, input logic [1:0] vc);
    chk(tag, {3'b000, bus.NZP_Out, bus.VC_Out}, {3'b000, nzp, vc});
  endtask

  task automatic chk_st(input string tag, input logic f, input logic e, input logic er);
    chk(tag, {5'b00000, bus.Stack_Full, bus.Stack_Empty, bus.Stack_Err}, {5'b00000, f, e, er});
  endtask

  task automatic chk_ben(input string tag, input logic b);
    chk(tag, {7'b0000000, bus.BEN_Out}, {7'b0000000, b});
  endtask

  task automatic clr();
    bus.Bus_In       = '0;
    bus.IR           = '0;
    bus.LD_CC        = 1'b0;
    bus.LD_BEN       = 1'b0;
    bus.Cmp_Unsigned = 1'b0;
    bus.Ovf_In       = 1'b0;
    bus.Carry_In     = 1'b0;
    bus.Cond_Mode    = 2'b00;
    bus.Save_CC      = 1'b0;
    bus.Restore_CC   = 1'b0;
  endtask

  task automatic ldcc(input logic [15:0] v, input logic o, input logic c);
    bus.LD_CC    = 1'b1;
    bus.Bus_In   = v;
    bus.Ovf_In   = o;
    bus.Carry_In = c;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    clr();
    #12;
    chk_cc("rst_cc", 3'b010, 2'b00);
    chk_ben("rst_ben", 1'b0);
    chk_st("rst_st", 1'b0, 1'b1, 1'b0);
    Reset = 1'b1;

    // CC loads
    clr(); ldcc(16'h8000, 1'b1, 1'b0); tick();
    chk_cc("ld_neg", 3'b100, 2'b10);
    clr(); ldcc(16'h8000, 1'b0, 1'b1); bus.Cmp_Unsigned = 1'b1; tick();
    chk_cc("ld_unsigned", 3'b001, 2'b01);
    clr(); ldcc(16'h0000, 1'b0, 1'b0); tick();
    chk_cc("ld_zero", 3'b010, 2'b00);
    clr(); ldcc(16'h0005, 1'b0, 1'b0); tick();
    chk_cc("ld_pos", 3'b001, 2'b00);

    // BEN with simultaneous LD_CC uses the old CC
    clr(); bus.IR = 16'h0200; ldcc(16'h0000, 1'b0, 1'b0); bus.LD_BEN = 1'b1; tick();
    chk_ben("ben_old_cc", 1'b1);
    chk_cc("ben_new_cc", 3'b010, 2'b00);
    clr(); bus.IR = 16'h0200; bus.LD_BEN = 1'b1; tick();
    chk_ben("ben_z_miss", 1'b0);

    // Other branch modes
    clr(); ldcc(16'h0001, 1'b0, 1'b1); tick();
    clr(); bus.IR = 16'h0200; bus.Cond_Mode = 2'b01; bus.LD_BEN = 1'b1; tick();
    chk_ben("ben_carry", 1'b1);
    clr(); bus.IR = 16'h0200; bus.Cond_Mode = 2'b10; bus.LD_BEN = 1'b1; tick();
    chk_ben("ben_ovf", 1'b0);
    clr(); bus.Cond_Mode = 2'b11; bus.LD_BEN = 1'b1; tick();
    chk_ben("ben_always", 1'b1);
    clr(); bus.Cond_Mode = 2'b10; tick();
    chk_ben("ben_hold", 1'b1);
    clr(); ldcc(16'h8000, 1'b0, 1'b0); tick();
    clr(); bus.IR = 16'h0800; bus.LD_BEN = 1'b1; tick();
    chk_ben("ben_n", 1'b1);

    // Fill the stack (CC is 100/00), pushing old CC while loading a new one
    clr(); bus.Save_CC = 1'b1; ldcc(16'h0000, 1'b1, 1'b0); tick();
    chk_cc("push0_cc", 3'b010, 2'b10);
    chk_st("push0_st", 1'b0, 1'b0, 1'b0);
    clr(); bus.Save_CC = 1'b1; ldcc(16'h0001, 1'b0, 1'b1); tick();
    clr(); bus.Save_CC = 1'b1; ldcc(16'h8000, 1'b1, 1'b1); tick();
    chk_st("push2_st", 1'b0, 1'b0, 1'b0);
    clr(); bus.Save_CC = 1'b1; tick();
    chk_st("push3_full", 1'b1, 1'b0, 1'b0);
    chk_cc("push3_cc", 3'b100, 2'b11);
    clr(); bus.Save_CC = 1'b1; tick();
    chk_st("push_ovf_st", 1'b1, 1'b0, 1'b1);
    chk_cc("push_ovf_cc", 3'b100, 2'b11);
    clr(); ldcc(16'h0000, 1'b0, 1'b0); tick();
    chk_cc("pre_pop_cc", 3'b010, 2'b00);

    clr(); bus.Restore_CC = 1'b1; tick();
    chk_cc("pop3_cc", 3'b100, 2'b11);
    chk_st("pop3_st", 1'b0, 1'b0, 1'b1);
    clr(); bus.Restore_CC = 1'b1; tick();
    chk_cc("pop2_cc", 3'b001, 2'b01);
    clr(); bus.Restore_CC = 1'b1; tick();
    chk_cc("pop1_cc", 3'b010, 2'b10);
    clr(); bus.Restore_CC = 1'b1; tick();
    chk_cc("pop0_cc", 3'b100, 2'b00);
    chk_st("pop0_st", 1'b0, 1'b1, 1'b1);

    // Reset clears the sticky error
    clr(); Reset = 1'b0; #2;
    chk_st("rst2_st", 1'b0, 1'b1, 1'b0);
    chk_cc("rst2_cc", 3'b010, 2'b00);
    Reset = 1'b1;

    // Save+Restore together is a no-op on the stack at ptr=2
    clr(); ldcc(16'h0005, 1'b0, 1'b1); tick();
    clr(); bus.Save_CC = 1'b1; tick();
    clr(); ldcc(16'h8000, 1'b0, 1'b0); tick();
    clr(); bus.Save_CC = 1'b1; tick();
    clr(); bus.Save_CC = 1'b1; bus.Restore_CC = 1'b1; tick();
    chk_cc("sr_nop_cc", 3'b100, 2'b00);
    chk_st("sr_nop_st", 1'b0, 1'b0, 1'b0);
    clr(); bus.Save_CC = 1'b1; bus.Restore_CC = 1'b1; ldcc(16'h0000, 1'b1, 1'b1); tick();
    chk_cc("sr_ld_cc", 3'b010, 2'b11);
    chk_st("sr_ld_st", 1'b0, 1'b0, 1'b0);
    clr(); bus.Restore_CC = 1'b1; tick();
    chk_cc("sr_pop1_cc", 3'b100, 2'b00);
    chk_st("sr_pop1_st", 1'b0, 1'b0, 1'b0);
    clr(); bus.Restore_CC = 1'b1; tick();
    chk_cc("sr_pop0_cc", 3'b001, 2'b01);
    chk_st("sr_pop0_st", 1'b0, 1'b1, 1'b0);

    // Restore when empty: error set, LD_CC still loads
    clr(); ldcc(16'h0000, 1'b0, 1'b0); tick();
    clr(); bus.Restore_CC = 1'b1; ldcc(16'h0005, 1'b1, 1'b0); tick();
    chk_cc("pop_empty_cc", 3'b001, 2'b10);
    chk_st("pop_empty_st", 1'b0, 1'b1, 1'b1);

    // Asynchronous reset between edges during a push sequence
    clr(); bus.Save_CC = 1'b1; tick();
    chk_st("apush_st", 1'b0, 1'b0, 1'b1);
    clr(); bus.Save_CC = 1'b1; #3;
    Reset = 1'b0; #1;
    chk_cc("arst_cc", 3'b010, 2'b00);
    chk_ben("arst_ben", 1'b0);
    chk_st("arst_st", 1'b0, 1'b1, 1'b0);
    #2;
    Reset = 1'b1;
    clr(); ldcc(16'h8000, 1'b0, 1'b1); tick();
    chk_cc("post_rst_cc", 3'b100, 2'b01);
    chk_st("post_rst_st", 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
